// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words and streams
// them with sequential word addresses to an instruction-memory write port.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        err,
    output logic [15:0] count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    logic [0:0]  state;
    logic [31:0] next_addr;
    logic [31:0] cur_addr;
    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        transfer;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    assign out_valid = (state == FULL);
    assign in_ready  = reset & ((state == EMPTY) | out_ready);
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;
    assign cur_addr  = restart ? BASE_ADDR : next_addr;

    // An N-bit signed immediate fits when all bits above N-1 equal the sign bit.
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_I: begin
                word  = {imm[11:0], rs1, funct3, rd, op};
                legal = fits12;
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                legal = fits12;
            end
            FMT_B: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                legal = fits13 & ~imm[0];
            end
            FMT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                legal = fits21 & ~imm[0];
            end
            FMT_U: begin
                word  = {imm[31:12], rd, op};
                legal = (imm[11:0] == 12'h000);
            end
            FMT_R: begin
                word  = {funct7, rs2, rs1, funct3, rd, op};
                legal = 1'b1;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    // A rejected request is consumed but leaves the output word, address and count alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= EMPTY;
            waddr     <= BASE_ADDR;
            wdata     <= '0;
            err       <= 1'b0;
            count     <= '0;
            next_addr <= BASE_ADDR;
        end else begin
            err <= accept & ~legal;
            if (accept && legal) begin
                state     <= FULL;
                wdata     <= word;
                waddr     <= cur_addr;
                next_addr <= cur_addr + 32'd4;
                count     <= count + 16'd1;
            end else begin
                if (transfer) begin
                    state <= EMPTY;
                end
                if (restart) begin
                    next_addr <= BASE_ADDR;
                end
            end
        end
    end

endmodule
